// File: rtl/alu_regfile_issue_if.sv
// Command channel between an issuing master and the ALU issue stage.
// The master presents one command under valid/ready; the issue stage drives ready.
interface alu_regfile_issue_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_rd;
    logic [ADDR_W-1:0] cmd_rs1;
    logic [ADDR_W-1:0] cmd_rs2;
    logic              cmd_imm_en;
    logic [DATA_W-1:0] cmd_imm;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm,
        output cmd_ready
    );
endinterface

// File: rtl/alu_regfile_issue.sv
// Issue stage for an external combinational ALU: register file, operand fetch,
// result capture and write-back, one command in flight (IDLE -> EXEC -> WB).
module alu_regfile_issue #(
    parameter int DATA_W  = 16,
    parameter int REG_NUM = 8,
    parameter int ADDR_W  = $clog2(REG_NUM)
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_regfile_issue_if.slave  cmd_if,
    output logic [DATA_W-1:0]   alu_operand1_o,
    output logic [DATA_W-1:0]   alu_operand2_o,
    output logic [3:0]          alu_control_o,
    input  logic [DATA_W-1:0]   alu_result_i,
    output logic                done_valid_o,
    output logic [ADDR_W-1:0]   done_rd_o,
    output logic [DATA_W-1:0]   done_data_o,
    input  logic                cfg_wr_en_i,
    input  logic [ADDR_W-1:0]   cfg_wr_addr_i,
    input  logic [DATA_W-1:0]   cfg_wr_data_i,
    input  logic [ADDR_W-1:0]   dbg_addr_i,
    output logic [DATA_W-1:0]   dbg_data_o
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] regs_q [REG_NUM];
    logic [ADDR_W-1:0] rd_q;
    logic [ADDR_W-1:0] done_rd_q;
    logic [DATA_W-1:0] done_data_q;
    logic              done_valid_q;
    logic [DATA_W-1:0] operand1_q;
    logic [DATA_W-1:0] operand2_q;
    logic [3:0]        control_q;

    logic              cmd_fire;
    logic [DATA_W-1:0] operand1_d;
    logic [DATA_W-1:0] operand2_d;

    // A host write in the same cycle blocks acceptance, so operand fetch never races it.
    assign cmd_if.cmd_ready = (state_q == IDLE) && !cfg_wr_en_i;
    assign cmd_fire         = cmd_if.cmd_valid && cmd_if.cmd_ready;

    always_comb begin
        operand1_d = '0;
        operand2_d = '0;
        if (cmd_if.cmd_rs1 != '0) begin
            operand1_d = regs_q[cmd_if.cmd_rs1];
        end
        if (cmd_if.cmd_imm_en) begin
            operand2_d = cmd_if.cmd_imm;
        end else if (cmd_if.cmd_rs2 != '0) begin
            operand2_d = regs_q[cmd_if.cmd_rs2];
        end
    end

    // Write-back is assigned after the host write so it wins a same-register collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
            rd_q         <= '0;
            done_rd_q    <= '0;
            done_data_q  <= '0;
            done_valid_q <= 1'b0;
            operand1_q   <= '0;
            operand2_q   <= '0;
            control_q    <= '0;
        end else begin
            if (cfg_wr_en_i && (cfg_wr_addr_i != '0)) begin
                regs_q[cfg_wr_addr_i] <= cfg_wr_data_i;
            end
            unique case (state_q)
                IDLE: begin
                    if (cmd_fire) begin
                        operand1_q <= operand1_d;
                        operand2_q <= operand2_d;
                        control_q  <= cmd_if.cmd_op;
                        rd_q       <= cmd_if.cmd_rd;
                        state_q    <= EXEC;
                    end
                end
                EXEC: begin
                    done_data_q  <= alu_result_i;
                    done_rd_q    <= rd_q;
                    done_valid_q <= 1'b1;
                    state_q      <= WB;
                end
                WB: begin
                    done_valid_q <= 1'b0;
                    if (done_rd_q != '0) begin
                        regs_q[done_rd_q] <= done_data_q;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_operand1_o = operand1_q;
    assign alu_operand2_o = operand2_q;
    assign alu_control_o  = control_q;
    assign done_valid_o   = done_valid_q;
    assign done_rd_o      = done_rd_q;
    assign done_data_o    = done_data_q;
    assign dbg_data_o     = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: tb/tb_alu_regfile_issue.sv
// Bench for alu_regfile_issue: a stand-in ALU, a transaction-level register model
// checked every cycle, and directed scenarios with hand-computed results.
module tb_alu_regfile_issue;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 3;
    localparam int REG_NUM = 8;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SHL  = 4'h5;
    localparam logic [3:0] OP_SHR  = 4'h6;
    localparam logic [3:0] OP_NONE = 4'hF;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_regfile_issue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) cmdIf ();

    logic [DATA_W-1:0] aluOperand1, aluOperand2, aluResult, doneData, cfgWrData, dbgData;
    logic [3:0]        aluControl;
    logic              doneValid, cfgWrEn;
    logic [ADDR_W-1:0] doneRd, cfgWrAddr, dbgAddr;

    int errors = 0;
    int checks = 0;

    function automatic logic [DATA_W-1:0] aluRef(input logic [3:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SHL:  return a << b[3:0];
            OP_SHR:  return a >> b[3:0];
            default: return '0;
        endcase
    endfunction

    assign aluResult = aluRef(aluControl, aluOperand1, aluOperand2);

    alu_regfile_issue #(.DATA_W(DATA_W), .REG_NUM(REG_NUM), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_if         (cmdIf),
        .alu_operand1_o (aluOperand1),
        .alu_operand2_o (aluOperand2),
        .alu_control_o  (aluControl),
        .alu_result_i   (aluResult),
        .done_valid_o   (doneValid),
        .done_rd_o      (doneRd),
        .done_data_o    (doneData),
        .cfg_wr_en_i    (cfgWrEn),
        .cfg_wr_addr_i  (cfgWrAddr),
        .cfg_wr_data_i  (cfgWrData),
        .dbg_addr_i     (dbgAddr),
        .dbg_data_o     (dbgData)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: register array plus the single in-flight command; age -1 none, 0 execute, 1 write-back.
    logic [DATA_W-1:0] mRegs [REG_NUM];
    int                age = -1;
    logic [3:0]        mOp = '0;
    logic [ADDR_W-1:0] mRd = '0;
    logic [DATA_W-1:0] mA = '0;
    logic [DATA_W-1:0] mB = '0;
    bit                mAccept;
    bit                modelValid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) mRegs[i] = '0;
            age = -1;
            mOp = '0; mRd = '0; mA = '0; mB = '0;
            modelValid = 1'b1;
        end else begin
            mAccept = (age < 0) && (cmdIf.cmd_valid === 1'b1) && !cfgWrEn;
            if (mAccept) begin
                mOp = cmdIf.cmd_op;
                mRd = cmdIf.cmd_rd;
                mA  = (cmdIf.cmd_rs1 == 0) ? '0 : mRegs[cmdIf.cmd_rs1];
                mB  = cmdIf.cmd_imm_en ? cmdIf.cmd_imm
                                       : ((cmdIf.cmd_rs2 == 0) ? '0 : mRegs[cmdIf.cmd_rs2]);
            end
            if (cfgWrEn && cfgWrAddr != 0) mRegs[cfgWrAddr] = cfgWrData;
            if (age == 1 && mRd != 0) mRegs[mRd] = aluRef(mOp, mA, mB);
            age = mAccept ? 0 : ((age == 0) ? 1 : -1);
        end
    end

    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("m_cmd_ready", cmdIf.cmd_ready, (age < 0) && !cfgWrEn);
            checkOutput("m_done_valid", doneValid, age == 1);
            if (age == 1) begin
                checkOutput("m_done_rd", doneRd, mRd);
                checkOutput("m_done_data", doneData, aluRef(mOp, mA, mB));
            end
            checkOutput("m_operand1", aluOperand1, mA);
            checkOutput("m_operand2", aluOperand2, mB);
            checkOutput("m_control", aluControl, mOp);
            checkOutput("m_dbg_data", dbgData, (dbgAddr == 0) ? '0 : mRegs[dbgAddr]);
        end
    end

    task automatic setCmd(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input logic immEn, input logic [15:0] imm);
        cmdIf.cmd_op     = op;
        cmdIf.cmd_rd     = rd;
        cmdIf.cmd_rs1    = rs1;
        cmdIf.cmd_rs2    = rs2;
        cmdIf.cmd_imm_en = immEn;
        cmdIf.cmd_imm    = imm;
    endtask

    task automatic cfgWrite(input logic [2:0] addr, input logic [15:0] data);
        cfgWrEn   = 1'b1;
        cfgWrAddr = addr;
        cfgWrData = data;
        @(posedge clk); #1;
        cfgWrEn   = 1'b0;
    endtask

    // Returns one time step after the accepting edge, with the stage in its execute cycle.
    task automatic applyStimulus(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                                 input logic [2:0] rs2, input logic immEn, input logic [15:0] imm);
        bit accepted = 1'b0;
        setCmd(op, rd, rs1, rs2, immEn, imm);
        cmdIf.cmd_valid = 1'b1;
        for (int i = 0; i < 10 && !accepted; i++) begin
            @(negedge clk);
            if (cmdIf.cmd_ready === 1'b1) accepted = 1'b1;
            @(posedge clk); #1;
        end
        cmdIf.cmd_valid = 1'b0;
        checkOutput("accept", accepted, 1);
    endtask

    task automatic waitDone(input string name, input logic [2:0] expRd, input logic [15:0] expData);
        int  lat  = 0;
        bit  seen = 1'b0;
        for (int i = 1; i <= 8 && !seen; i++) begin
            @(negedge clk);
            checkOutput({name, "_busy_ready"}, cmdIf.cmd_ready, 0);
            if (doneValid === 1'b1) begin
                seen = 1'b1;
                lat  = i;
                checkOutput({name, "_rd"}, doneRd, expRd);
                checkOutput({name, "_data"}, doneData, expData);
            end
        end
        checkOutput({name, "_latency"}, lat, 2);
        @(posedge clk); #1;
    endtask

    task automatic checkDbg(input string name, input logic [2:0] addr, input logic [15:0] expected);
        dbgAddr = addr;
        #1;
        checkOutput(name, dbgData, expected);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        cfgWrEn = 1'b0; cfgWrAddr = '0; cfgWrData = '0; dbgAddr = '0;
        cmdIf.cmd_valid = 1'b0;
        setCmd(OP_ADD, 0, 0, 0, 1'b0, 16'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        checkOutput("rst_operand1", aluOperand1, 0);
        checkOutput("rst_operand2", aluOperand2, 0);
        checkOutput("rst_control", aluControl, 0);
        checkOutput("rst_done_valid", doneValid, 0);
        checkOutput("rst_done_rd", doneRd, 0);
        checkOutput("rst_done_data", doneData, 0);
        checkOutput("rst_cmd_ready", cmdIf.cmd_ready, 1);
        for (int r = 0; r < REG_NUM; r++) checkDbg("rst_reg", 3'(r), 16'h0000);

        cfgWrite(3'd1, 16'h0005);
        cfgWrite(3'd2, 16'h0003);
        checkDbg("cfg_r1", 3'd1, 16'h0005);

        applyStimulus(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0);
        waitDone("add", 3'd3, 16'h0008);
        checkDbg("add_r3", 3'd3, 16'h0008);

        applyStimulus(OP_SUB, 3'd4, 3'd2, 3'd1, 1'b0, 16'h0);
        waitDone("sub", 3'd4, 16'hFFFE);
        checkDbg("sub_r4", 3'd4, 16'hFFFE);

        applyStimulus(OP_SHL, 3'd5, 3'd1, 3'd7, 1'b1, 16'h0004);
        waitDone("shl_imm", 3'd5, 16'h0050);
        checkDbg("shl_r5", 3'd5, 16'h0050);

        applyStimulus(OP_XOR, 3'd6, 3'd4, 3'd5, 1'b0, 16'h0);
        waitDone("xor", 3'd6, 16'hFFAE);

        applyStimulus(OP_NONE, 3'd6, 3'd1, 3'd2, 1'b0, 16'h0);
        waitDone("op_f", 3'd6, 16'h0000);
        checkDbg("op_f_r6", 3'd6, 16'h0000);

        applyStimulus(OP_ADD, 3'd0, 3'd1, 3'd2, 1'b0, 16'h0);
        waitDone("add_r0", 3'd0, 16'h0008);
        checkDbg("wb_r0", 3'd0, 16'h0000);
        cfgWrite(3'd0, 16'hFFFF);
        checkDbg("cfg_r0", 3'd0, 16'h0000);

        // Reset while a command is executing, with cmd_valid held across it.
        setCmd(OP_ADD, 3'd7, 3'd1, 3'd2, 1'b0, 16'h0);
        cmdIf.cmd_valid = 1'b1;
        @(negedge clk);
        checkOutput("rstx_ready_pre", cmdIf.cmd_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rstx_exec_done_valid", doneValid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("rstx_done_valid", doneValid, 0);
        checkOutput("rstx_ready", cmdIf.cmd_ready, 1);
        checkDbg("rstx_r1", 3'd1, 16'h0000);
        checkDbg("rstx_r3", 3'd3, 16'h0000);
        @(posedge clk); #1;
        cmdIf.cmd_valid = 1'b0;
        waitDone("rstx", 3'd7, 16'h0000);

        // Host write colliding with write-back to the same register.
        cfgWrite(3'd1, 16'h0005);
        cfgWrite(3'd2, 16'h0003);
        applyStimulus(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0);
        @(posedge clk); #1;
        checkOutput("col_done_valid", doneValid, 1);
        cfgWrEn = 1'b1; cfgWrAddr = 3'd3; cfgWrData = 16'h1234;
        @(posedge clk); #1;
        cfgWrEn = 1'b0;
        checkDbg("col_r3", 3'd3, 16'h0008);

        // Host write in IDLE blocks acceptance for that cycle only.
        cfgWrEn = 1'b1; cfgWrAddr = 3'd2; cfgWrData = 16'h0007;
        setCmd(OP_ADD, 3'd6, 3'd1, 3'd2, 1'b0, 16'h0);
        cmdIf.cmd_valid = 1'b1;
        @(negedge clk);
        checkOutput("pri_ready_blocked", cmdIf.cmd_ready, 0);
        @(posedge clk); #1;
        cfgWrEn = 1'b0;
        @(negedge clk);
        checkOutput("pri_ready", cmdIf.cmd_ready, 1);
        @(posedge clk); #1;
        cmdIf.cmd_valid = 1'b0;
        waitDone("pri", 3'd6, 16'h000C);
        checkDbg("pri_r6", 3'd6, 16'h000C);

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
